// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_pkg
//  Description : Shared constants, flag indices and operand classes for the
//                single-precision multiplier post-processing stage.
//  Revision    : 1.0
// ============================================================================
package fp_pkg;

    localparam logic [7:0]  EXP_BIAS     = 8'd127;
    localparam logic [7:0]  EXP_MAX      = 8'd255;
    localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF      = 32'h7F80_0000;

    localparam int FLG_INV  = 3;
    localparam int FLG_OVF  = 2;
    localparam int FLG_UNF  = 1;
    localparam int FLG_ZERO = 0;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } fp_cls_e;

endpackage
`default_nettype wire

// File: rtl/fp_mult_post_classify.sv
`default_nettype none
// ============================================================================
//  Module      : fp_classify
//  Description : Combinational single-operand classifier (zero/inf/nan/norm),
//                subnormals treated as zero.
//  Revision    : 1.0
// ============================================================================
module fp_classify
    import fp_pkg::*;
(
    input  logic [30:0] mag,
    output fp_cls_e     cls
);

    always_comb begin
        cls = CLS_NORM;
        if (mag[30:23] == 8'd0) begin
            cls = CLS_ZERO;
        end else if (mag[30:23] == EXP_MAX) begin
            cls = (mag[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_mult_post.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mult_post
//  Description : Two-stage valid/ready post-processor that turns the raw
//                multiplier core output into an IEEE-754 FTZ result + flags.
//  Revision    : 1.0
// ============================================================================
module fp_mult_post
    import fp_pkg::*;
#(
    parameter logic [31:0] QNAN      = QNAN_DEFAULT,
    parameter int          STICKY_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [31:0] raw_prod,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  sticky_flags,
    input  logic        flag_clr
);

    fp_cls_e            w_cls_a, w_cls_b;
    logic               w_adv1, w_adv2;
    logic [7:0]         w_exp_off;
    logic               w_norm;
    logic [9:0]         w_esum;
    logic [9:0]         w_etrue;
    logic               w_unused_sign;

    logic               r_s1_valid;
    logic               r_s1_sign;
    fp_cls_e            r_s1_cls_a, r_s1_cls_b;
    logic signed [9:0]  r_s1_etrue;
    logic [22:0]        r_s1_mant;

    logic               r_s2_valid;
    logic [31:0]        w_res;
    logic [3:0]         w_flg;

    fp_classify u_cls_a (.mag(op_a[30:0]), .cls(w_cls_a));
    fp_classify u_cls_b (.mag(op_b[30:0]), .cls(w_cls_b));

    assign w_adv2   = !r_s2_valid | out_ready;
    assign w_adv1   = !r_s1_valid | w_adv2;
    assign in_ready = w_adv1;
    assign out_valid = r_s2_valid;

    // The core's wrapped exponent differs from (Ea+Eb+129) mod 256 by only 0
    // or 1, so the low bit of the difference (an XOR) is the normalise shift.
    assign w_exp_off = op_a[30:23] + op_b[30:23] + 8'd129;
    assign w_norm    = raw_prod[23] ^ w_exp_off[0];
    assign w_esum    = {2'b00, op_a[30:23]} + {2'b00, op_b[30:23]} - {2'b00, EXP_BIAS};
    assign w_etrue   = w_esum + {9'd0, w_norm};
    assign w_unused_sign = raw_prod[31];

    // ---------------- S1: classify ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1 && in_valid) begin
            r_s1_sign  <= op_a[31] ^ op_b[31];
            r_s1_cls_a <= w_cls_a;
            r_s1_cls_b <= w_cls_b;
            r_s1_etrue <= signed'(w_etrue);
            r_s1_mant  <= raw_prod[22:0];
        end
    end

    // ---------------- S2: compose, priority ordered ----------------
    always_comb begin
        w_res = {r_s1_sign, 31'd0};
        w_flg = 4'd0;
        if ((r_s1_cls_a == CLS_NAN) || (r_s1_cls_b == CLS_NAN) ||
            ((r_s1_cls_a == CLS_INF) && (r_s1_cls_b == CLS_ZERO)) ||
            ((r_s1_cls_a == CLS_ZERO) && (r_s1_cls_b == CLS_INF))) begin
            w_res          = QNAN;
            w_flg[FLG_INV] = 1'b1;
        end else if ((r_s1_cls_a == CLS_INF) || (r_s1_cls_b == CLS_INF)) begin
            w_res = {r_s1_sign, POS_INF[30:0]};
        end else if ((r_s1_cls_a == CLS_ZERO) || (r_s1_cls_b == CLS_ZERO)) begin
            w_flg[FLG_ZERO] = 1'b1;
        end else if (r_s1_etrue >= 10'sd255) begin
            w_res          = {r_s1_sign, POS_INF[30:0]};
            w_flg[FLG_OVF] = 1'b1;
        end else if (r_s1_etrue <= 10'sd0) begin
            w_flg[FLG_UNF]  = 1'b1;
            w_flg[FLG_ZERO] = 1'b1;
        end else begin
            w_res = {r_s1_sign, r_s1_etrue[7:0], r_s1_mant};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            result     <= 32'd0;
            flags      <= 4'd0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                result <= w_res;
                flags  <= w_flg;
            end
        end
    end

    // ---------------- sticky status ----------------
    generate
        if (STICKY_EN != 0) begin : g_sticky
            logic [3:0] r_sticky;
            always_ff @(posedge clk) begin
                if (rst || flag_clr) begin
                    r_sticky <= 4'd0;
                end else if (r_s2_valid && out_ready) begin
                    r_sticky <= r_sticky | flags;
                end
            end
            assign sticky_flags = r_sticky;
        end else begin : g_no_sticky
            logic w_unused_clr;
            assign w_unused_clr = flag_clr;
            assign sticky_flags = 4'd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_post.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mult_post
//  Description : Scoreboard bench for fp_mult_post: directed vectors, sticky
//                flags, backpressure and mid-stream reset.
//  Revision    : 1.0
// ============================================================================
module tb_fp_mult_post;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] op_a, op_b, raw_prod;
    logic        in_valid, in_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        out_valid, out_ready;
    logic [3:0]  sticky_flags;
    logic        flag_clr;

    always #5 clk = ~clk;

    fp_mult_post dut (
        .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .raw_prod(raw_prod),
        .in_valid(in_valid), .in_ready(in_ready), .result(result), .flags(flags),
        .out_valid(out_valid), .out_ready(out_ready),
        .sticky_flags(sticky_flags), .flag_clr(flag_clr)
    );

    typedef struct packed {
        logic [31:0] a, b, raw, res;
        logic [3:0]  flg;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    vec_t vecs [14];
    exp_t sb [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic send(input vec_t v);
        op_a = v.a; op_b = v.b; raw_prod = v.raw; in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("accept", {31'd0, in_ready}, 32'd1);
        sb.push_back({v.res, v.flg});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && sb.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        chk("drain", sb.size(), 32'd0);
    endtask

    task automatic clear_sticky();
        flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("sticky_clr", {28'd0, sticky_flags}, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("stale_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("flags", {28'd0, flags}, {28'd0, e.flg});
            end
        end
    end

    initial begin
        //              op_a          op_b          raw_prod      result        flags
        vecs[0]  = '{32'h40000000, 32'h40400000, 32'h40C00000, 32'h40C00000, 4'b0000};
        vecs[1]  = '{32'h7F000000, 32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0100};
        vecs[2]  = '{32'h00800000, 32'h00800000, 32'h41800000, 32'h00000000, 4'b0011};
        vecs[3]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 32'h40100000, 4'b0000};
        vecs[4]  = '{32'hC0000000, 32'h40400000, 32'hC0C00000, 32'hC0C00000, 4'b0000};
        vecs[5]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, 32'h7F800000, 4'b0100};
        vecs[6]  = '{32'h7E800000, 32'h40000000, 32'h7F000000, 32'h7F000000, 4'b0000};
        vecs[7]  = '{32'h00800000, 32'h3F000000, 32'h00000000, 32'h00000000, 4'b0011};
        vecs[8]  = '{32'h00800000, 32'h3F800000, 32'h00800000, 32'h00800000, 4'b0000};
        vecs[9]  = '{32'h7F800000, 32'hC0000000, 32'h7F800000, 32'hFF800000, 4'b0000};
        vecs[10] = '{32'h00000000, 32'hBF800000, 32'h80000000, 32'h80000000, 4'b0001};
        vecs[11] = '{32'h00000001, 32'h40000000, 32'h00800000, 32'h00000000, 4'b0001};
        vecs[12] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00001, 32'h7FC00000, 4'b1000};
        vecs[13] = '{32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000};

        rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; raw_prod = '0;
        out_ready = 1'b1; flag_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_sticky", {28'd0, sticky_flags}, 32'd0);
        rst = 1'b0;

        // Back-to-back stream of non-invalid vectors
        for (int i = 0; i < 12; i++) send(vecs[i]);
        drain();
        chk("sticky_stream", {28'd0, sticky_flags}, 32'd7);
        clear_sticky();

        // Invalid operations
        send(vecs[12]);
        send(vecs[13]);
        drain();
        chk("sticky_inv", {28'd0, sticky_flags}, 32'd8);
        clear_sticky();

        // Backpressure: two accepted, third stalls, output held
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        op_a = vecs[2].a; op_b = vecs[2].b; raw_prod = vecs[2].raw; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (3) @(negedge clk);
        chk("bp_hold_result", result, vecs[0].res);
        chk("bp_hold_flags", {28'd0, flags}, {28'd0, vecs[0].flg});
        chk("bp_in_ready2", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(vecs[2]);
        drain();

        // flag_clr wins over a simultaneous output transfer
        out_ready = 1'b0;
        send(vecs[1]);
        for (int i = 0; i < 16 && !out_valid; i++) @(negedge clk);
        chk("clr_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1; flag_clr = 1'b1;
        @(posedge clk); #1;
        flag_clr = 1'b0;
        chk("clr_priority", {28'd0, sticky_flags}, 32'd0);

        // Reset with both stages full
        send(vecs[2]);
        drain();
        chk("sticky_pre_rst", {28'd0, sticky_flags}, 32'd3);
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[3]);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_sticky", {28'd0, sticky_flags}, 32'd0);
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(vecs[4]);
        drain();
        chk("sticky_post_rst", {28'd0, sticky_flags}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
